// File: rtl/framestore_responder_pkg.sv
// Shared framestore definitions: address widths, responder state encoding and
// read/write encoding used by the edge-detector and display blocks.
package framestore_responder_pkg;

  localparam int DE_ADDR_W  = 18;
  localparam int MEM_ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    WAIT = 2'd2,
    ACK  = 2'd3
  } fs_state_t;

  typedef enum logic {
    RNW_WRITE = 1'b0,
    RNW_READ  = 1'b1
  } fs_rnw_t;

endpackage

// File: rtl/framestore_responder_wait_counter.sv
// Wait-state down-counter: load presets the count, tick decrements it,
// done flags terminal count (zero).
module fs_wait_counter #(
  parameter int               WIDTH    = 4,
  parameter logic [WIDTH-1:0] LOAD_VAL = '0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic tick,
  output logic done
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (tick && !done) begin
      count <= count - WIDTH'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/framestore_responder.sv
// Framestore responder: serves drawing-engine word accesses onto a synchronous SRAM.
// Define FS_BOUNDS_CHECK_EN to block and flag accesses at or beyond FRAME_WORDS.
//
// state | meaning
// IDLE  | waiting for de_req; on request, strobe SRAM and latch request kind
// MEM   | SRAM samples the strobe; strobe released
// WAIT  | WAIT_CYCLES extra memory wait states (skipped when zero)
// ACK   | read data captured, de_ack raised for the following cycle
module framestore_responder
  import framestore_responder_pkg::*;
#(
  parameter int WAIT_CYCLES = 0,
  parameter int FRAME_WORDS = 65536
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  de_req,
  output logic                  de_ack,
  input  logic [DE_ADDR_W-1:0]  de_addr,
  input  logic [3:0]            de_nbyte,
  input  logic                  de_rnw,
  input  logic [31:0]           de_w_data,
  output logic [31:0]           de_r_data,
  output logic                  mem_en,
  output logic [3:0]            mem_we,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  output logic                  err
);

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  fs_state_t             state, state_nx;
  fs_rnw_t               rnw_q, rnw_nx;
  logic                  oob_q, oob_nx;
  logic                  oob;
  logic                  wait_done;
  logic [MEM_ADDR_W-1:0] word;
  logic                  unused_addr_lsbs;

  logic                  de_ack_nx, mem_en_nx, err_nx;
  logic [3:0]            mem_we_nx;
  logic [MEM_ADDR_W-1:0] mem_addr_nx;
  logic [31:0]           mem_wdata_nx, r_data_nx;

  assign word             = de_addr[DE_ADDR_W-1:2];
  assign unused_addr_lsbs = ^de_addr[1:0];

`ifdef FS_BOUNDS_CHECK_EN
  localparam logic [MEM_ADDR_W:0] FRAME_LIMIT = (MEM_ADDR_W + 1)'(FRAME_WORDS);
  assign oob = ({1'b0, word} >= FRAME_LIMIT);
`else
  logic [31:0] unused_frame_words;
  assign unused_frame_words = FRAME_WORDS;
  assign oob = 1'b0;
`endif

  fs_wait_counter #(
    .WIDTH    (4),
    .LOAD_VAL (WAIT_LOAD)
  ) u_wait (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (state == MEM),
    .tick  (state == WAIT),
    .done  (wait_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rnw_q     <= RNW_READ;
      oob_q     <= 1'b0;
      de_ack    <= 1'b0;
      de_r_data <= '0;
      mem_en    <= 1'b0;
      mem_we    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_nx;
      rnw_q     <= rnw_nx;
      oob_q     <= oob_nx;
      de_ack    <= de_ack_nx;
      de_r_data <= r_data_nx;
      mem_en    <= mem_en_nx;
      mem_we    <= mem_we_nx;
      mem_addr  <= mem_addr_nx;
      mem_wdata <= mem_wdata_nx;
      err       <= err_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (de_req) state_nx = MEM;
      MEM:     state_nx = (WAIT_CYCLES == 0) ? ACK : WAIT;
      WAIT:    if (wait_done) state_nx = ACK;
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    rnw_nx       = rnw_q;
    oob_nx       = oob_q;
    de_ack_nx    = 1'b0;
    mem_en_nx    = 1'b0;
    mem_we_nx    = '0;
    mem_addr_nx  = mem_addr;
    mem_wdata_nx = mem_wdata;
    r_data_nx    = de_r_data;
    err_nx       = err;
    case (state)
      IDLE: begin
        if (de_req) begin
          rnw_nx      = fs_rnw_t'(de_rnw);
          oob_nx      = oob;
          mem_addr_nx = word;
          mem_en_nx   = !oob;
          err_nx      = err | oob;
          if (fs_rnw_t'(de_rnw) == RNW_WRITE && !oob) begin
            mem_we_nx    = ~de_nbyte;
            mem_wdata_nx = de_w_data;
          end
        end
      end
      ACK: begin
        de_ack_nx = 1'b1;
        // Blocked reads return zero instead of whatever the SRAM port holds.
        if (rnw_q == RNW_READ) r_data_nx = oob_q ? '0 : mem_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_framestore_responder.sv
// Self-checking bench for framestore_responder: randomized accesses against a
// transaction-level model, plus directed checks on a zero- and a three-wait instance.
module tb_framestore_responder;

  localparam int WA  = 0;
  localparam int WB  = 3;
  localparam int FWA = 1024;

  typedef struct {
    int          s;
    logic        rnw;
    logic [15:0] word;
    logic [3:0]  nbyte;
    logic [31:0] wdata;
    logic [31:0] rexp;
    logic        oob;
  } txn_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rst_n_b;
  logic        req_a, ack_a, rnw_a, en_a, err_a;
  logic [17:0] addr_a;
  logic [3:0]  nbyte_a, we_a;
  logic [31:0] wd_a, rd_a, mwd_a, mrd_a;
  logic [15:0] maddr_a;
  logic        req_b, ack_b, rnw_b, en_b, err_b;
  logic [17:0] addr_b;
  logic [3:0]  nbyte_b, we_b;
  logic [31:0] wd_b, rd_b, mwd_b, mrd_b;
  logic [15:0] maddr_b;

  framestore_responder #(.WAIT_CYCLES(WA), .FRAME_WORDS(FWA)) dut_a (
    .clk(clk), .rst_n(rst_n), .de_req(req_a), .de_ack(ack_a), .de_addr(addr_a),
    .de_nbyte(nbyte_a), .de_rnw(rnw_a), .de_w_data(wd_a), .de_r_data(rd_a),
    .mem_en(en_a), .mem_we(we_a), .mem_addr(maddr_a), .mem_wdata(mwd_a),
    .mem_rdata(mrd_a), .err(err_a));

  framestore_responder #(.WAIT_CYCLES(WB), .FRAME_WORDS(FWA)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .de_req(req_b), .de_ack(ack_b), .de_addr(addr_b),
    .de_nbyte(nbyte_b), .de_rnw(rnw_b), .de_w_data(wd_b), .de_r_data(rd_b),
    .mem_en(en_b), .mem_we(we_b), .mem_addr(maddr_b), .mem_wdata(mwd_b),
    .mem_rdata(mrd_b), .err(err_b));

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // SRAM behaviour for both instances: read-first, data one cycle after the strobe.
  logic [31:0] mem_a [0:2047];
  logic [31:0] ref_mem [0:2047];
  logic [31:0] mem_b [0:63];
  logic [31:0] tmp_a, tmp_b;

  always @(posedge clk) begin
    if (en_a) begin
      tmp_a = mem_a[maddr_a[10:0]];
      mrd_a <= tmp_a;
      for (int l = 0; l < 4; l++) if (we_a[l]) tmp_a[8*l +: 8] = mwd_a[8*l +: 8];
      mem_a[maddr_a[10:0]] <= tmp_a;
    end
  end

  always @(posedge clk) begin
    if (en_b) begin
      tmp_b = mem_b[maddr_b[5:0]];
      mrd_b <= tmp_b;
      for (int l = 0; l < 4; l++) if (we_b[l]) tmp_b[8*l +: 8] = mwd_b[8*l +: 8];
      mem_b[maddr_b[5:0]] <= tmp_b;
    end
  end

  // Per-cycle logs for the directed literal checks.
  logic        en_log [int];
  logic [3:0]  we_log [int];
  logic [15:0] addr_log [int];
  int n_ack_a = 0;
  int n_ack_b = 0;
  always @(negedge clk) begin
    en_log[cyc]   = en_a;
    we_log[cyc]   = we_a;
    addr_log[cyc] = maddr_a;
    if (ack_a) n_ack_a++;
    if (ack_b) n_ack_b++;
  end

  // Transaction-level model of instance A.
  txn_t        pend [$];
  bit          chk_en = 1'b0;
  logic        e_en, e_ack, e_chk_addr, exp_err;
  logic [3:0]  e_we;
  logic [15:0] e_addr;
  logic [31:0] e_wd, exp_rdata;

  always @(negedge clk) begin
    if (chk_en) begin
      e_en = 1'b0; e_ack = 1'b0; e_we = '0; e_chk_addr = 1'b0; e_addr = '0; e_wd = '0;
      while (pend.size() > 0 && pend[0].s + 2 + WA < cyc) pend.delete(0);
      foreach (pend[i]) begin
        if (pend[i].s == cyc) begin
          e_chk_addr = 1'b1;
          e_addr     = pend[i].word;
          e_en       = !pend[i].oob;
          if (!pend[i].rnw && !pend[i].oob) begin
            e_we = ~pend[i].nbyte;
            e_wd = pend[i].wdata;
          end
          if (pend[i].oob) exp_err = 1'b1;
        end
        if (pend[i].s + 2 + WA == cyc) begin
          e_ack = 1'b1;
          if (pend[i].rnw) exp_rdata = pend[i].rexp;
        end
      end
      chk("mem_en", en_a, e_en);
      chk("mem_we", we_a, e_we);
      chk("de_ack", ack_a, e_ack);
      chk("de_r_data", rd_a, exp_rdata);
      chk("err", err_a, exp_err);
      if (e_chk_addr) chk("mem_addr", maddr_a, e_addr);
      if (e_we != 0) chk("mem_wdata", mwd_a, e_wd);
    end
  end

  task automatic issue_a(input logic rnw, input logic [17:0] addr, input logic [3:0] nbyte,
                         input logic [31:0] wd, input bit drop, output int ack_at);
    txn_t        t;
    logic [15:0] w;
    logic [31:0] m;
    w       = addr[17:2];
    t.s     = cyc + 1;
    t.rnw   = rnw;
    t.word  = w;
    t.nbyte = nbyte;
    t.wdata = wd;
`ifdef FS_BOUNDS_CHECK_EN
    t.oob = (w >= 16'(FWA));
`else
    t.oob = 1'b0;
`endif
    t.rexp = t.oob ? 32'h0 : ref_mem[w[10:0]];
    if (!rnw && !t.oob) begin
      m = ref_mem[w[10:0]];
      for (int l = 0; l < 4; l++) if (!nbyte[l]) m[8*l +: 8] = wd[8*l +: 8];
      ref_mem[w[10:0]] = m;
    end
    pend.push_back(t);
    req_a = 1'b1; rnw_a = rnw; addr_a = addr; nbyte_a = nbyte; wd_a = wd;
    ack_at = -1;
    for (int k = 0; k < 40 && ack_at < 0; k++) begin
      @(posedge clk); #1;
      if (drop) req_a = 1'b0;
      if (ack_a) ack_at = cyc;
    end
    chk("ack_a_seen", 32'(ack_at >= 0), 32'd1);
  endtask

  task automatic issue_b(input logic rnw, input logic [17:0] addr, input logic [3:0] nbyte,
                         input logic [31:0] wd, output int lat);
    int s;
    s = cyc + 1;
    req_b = 1'b1; rnw_b = rnw; addr_b = addr; nbyte_b = nbyte; wd_b = wd;
    lat = -1;
    for (int k = 0; k < 40 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (ack_b) lat = cyc - s;
    end
    req_b = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int s, at, g, na;
    int ack_t [4];
    logic [15:0] w;

    for (int i = 0; i < 2048; i++) begin
      mem_a[i]   = 32'(i) * 32'h9E3779B9;
      ref_mem[i] = 32'(i) * 32'h9E3779B9;
    end
    for (int i = 0; i < 64; i++) mem_b[i] = 32'(i) * 32'h01010101;
    mem_b[4] = 32'hDEADBEEF;
    mrd_a = '0; mrd_b = '0;
    exp_rdata = '0; exp_err = 1'b0;
    rst_n = 1'b0; rst_n_b = 1'b0;
    req_a = 0; rnw_a = 0; addr_a = '0; nbyte_a = '0; wd_a = '0;
    req_b = 0; rnw_b = 0; addr_b = '0; nbyte_b = '0; wd_b = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_de_ack", ack_a, 0);
    chk("rst_mem_en", en_a, 0);
    chk("rst_mem_we", we_a, 0);
    chk("rst_mem_addr", maddr_a, 0);
    chk("rst_mem_wdata", mwd_a, 0);
    chk("rst_de_r_data", rd_a, 0);
    chk("rst_err", err_a, 0);
    @(negedge clk);
    rst_n = 1'b1; rst_n_b = 1'b1; chk_en = 1'b1;
    @(posedge clk); #1;

    // Full-word write: strobe one cycle after sampling, ack two after.
    s = cyc + 1;
    issue_a(1'b0, 18'h00010, 4'b0000, 32'hDEADBEEF, 1'b0, at);
    chk("wr_mem_we", we_log[s], 4'b1111);
    chk("wr_mem_addr", addr_log[s], 16'h0004);
    chk("wr_latency", 32'(at - s), 32'd2);

    // Partial write: lanes 0 and 2 only.
    s = cyc + 1;
    issue_a(1'b0, 18'h00010, 4'b1010, 32'h11223344, 1'b0, at);
    req_a = 1'b0;
    chk("part_mem_we", we_log[s], 4'b0101);
    chk("part_mem_word", mem_a[4], 32'hDE22BE44);

    // Request held high over four reads.
    @(posedge clk); #1;
    na = n_ack_a;
    for (int i = 0; i < 4; i++) begin
      issue_a(1'b1, 18'h00010, 4'b0000, 32'h0, 1'b0, at);
      ack_t[i] = at;
    end
    req_a = 1'b0;
    chk("held_rdata", rd_a, 32'hDE22BE44);
    repeat (3) @(posedge clk); #1;
    chk("held_ack_count", 32'(n_ack_a - na), 32'd4);
    for (int i = 1; i < 4; i++) chk("held_ack_spacing", 32'(ack_t[i] - ack_t[i-1]), 32'd3);

    // Request dropped early still completes.
    s = cyc + 1;
    issue_a(1'b1, 18'h00010, 4'b0000, 32'h0, 1'b1, at);
    chk("drop_latency", 32'(at - s), 32'd2);

    // All lanes disabled: handshake and strobe without byte enables.
    s = cyc + 1;
    issue_a(1'b0, 18'h00024, 4'b1111, 32'hCAFEF00D, 1'b0, at);
    req_a = 1'b0;
    chk("nolane_mem_en", en_log[s], 1);
    chk("nolane_mem_we", we_log[s], 0);
    chk("nolane_latency", 32'(at - s), 32'd2);

    // Word 1024: out of range only when bounds checking is compiled in.
    @(posedge clk); #1;
    s = cyc + 1;
    issue_a(1'b1, 18'h01000, 4'b0000, 32'h0, 1'b0, at);
    req_a = 1'b0;
    chk("oob_latency", 32'(at - s), 32'd2);
`ifdef FS_BOUNDS_CHECK_EN
    chk("oob_mem_en", en_log[s], 0);
    chk("oob_rdata", rd_a, 32'h0);
    chk("oob_err", err_a, 1);
`else
    chk("oob_mem_en", en_log[s], 1);
    chk("oob_err", err_a, 0);
`endif

    // Randomized traffic.
    for (int n = 0; n < 250; n++) begin
      w = 16'($urandom_range(0, 2047));
      issue_a(1'($urandom_range(0, 1)), {w, 2'($urandom_range(0, 3))}, 4'($urandom_range(0, 15)),
              $urandom, ($urandom_range(0, 9) == 0), at);
      g = $urandom_range(0, 2);
      if (g != 0) begin
        req_a = 1'b0;
        repeat (g) @(posedge clk);
        #1;
      end
    end
    req_a = 1'b0;
    repeat (4) @(posedge clk); #1;
`ifdef FS_BOUNDS_CHECK_EN
    chk("err_sticky", err_a, 1);
`else
    chk("err_tied", err_a, 0);
`endif
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst2_err", err_a, 0);
    chk("rst2_de_r_data", rd_a, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Instance B: three wait states.
    @(posedge clk); #1;
    issue_b(1'b1, 18'h00010, 4'b0000, 32'h0, at);
    chk("b_rd_latency", 32'(at), 32'd5);
    chk("b_rd_data", rd_b, 32'hDEADBEEF);
    @(posedge clk); #1;
    chk("b_ack_width", ack_b, 0);

    // Reset during WAIT after the write strobe has gone out.
    req_b = 1'b1; rnw_b = 1'b0; addr_b = 18'h00020; nbyte_b = 4'b0000; wd_b = 32'h12345678;
    repeat (3) @(posedge clk);
    #1;
    na = n_ack_b;
    rst_n_b = 1'b0; req_b = 1'b0;
    #1;
    chk("b_rst_de_ack", ack_b, 0);
    chk("b_rst_de_r_data", rd_b, 0);
    chk("b_rst_mem_en", en_b, 0);
    chk("b_rst_mem_we", we_b, 0);
    chk("b_rst_mem_addr", maddr_b, 0);
    chk("b_rst_mem_wdata", mwd_b, 0);
    chk("b_rst_err", err_b, 0);
    chk("b_write_landed", mem_b[8], 32'h12345678);
    repeat (2) @(negedge clk);
    rst_n_b = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("b_no_ack_after_rst", 32'(n_ack_b - na), 32'd0);
    issue_b(1'b1, 18'h00020, 4'b0000, 32'h0, at);
    chk("b_post_rst_latency", 32'(at), 32'd5);
    chk("b_post_rst_data", rd_b, 32'h12345678);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/framestore_responder.md
FRAMESTORE_RESPONDER -- requirements
Module: framestore_responder

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 0, meaning extra memory wait states per access (0..15).
REQ-002 SHALL have parameter FRAME_WORDS, default 65536, meaning the number of valid 32-bit words in the framestore.
REQ-003 SHALL have port clk  in  1  sole clock, all state changes on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port de_req  in  1  request from the drawing/edge engine, held until acknowledged.
REQ-006 SHALL have port de_ack  out  1  one-cycle completion pulse.
REQ-007 SHALL have port de_addr  in  18  byte address; bits [17:2] form the word address and bits [1:0] are ignored.
REQ-008 SHALL have port de_nbyte  in  4  active-low byte-lane enables for writes; bit i low enables lane i.
REQ-009 SHALL have port de_rnw  in  1  1 = read, 0 = write.
REQ-010 SHALL have port de_w_data  in  32  write data.
REQ-011 SHALL have port de_r_data  out  32  read data, valid while de_ack = 1.
REQ-012 SHALL have port mem_en  out  1  synchronous SRAM access strobe.
REQ-013 SHALL have port mem_we  out  4  active-high byte write enables.
REQ-014 SHALL have port mem_addr  out  16  word address.
REQ-015 SHALL have port mem_wdata  out  32  SRAM write data.
REQ-016 SHALL have port mem_rdata  in  32  SRAM read data, valid one cycle after mem_en is sampled.
REQ-017 SHALL have port err  out  1  sticky out-of-range flag.

Function
REQ-018 SHALL implement the states IDLE, MEM, WAIT and ACK, with all outputs registered.
REQ-019 IDLE: on de_req = 1, SHALL latch the request fields, drive mem_en = 1 and mem_addr = de_addr[17:2], and go to MEM.
REQ-020 For a write, SHALL drive mem_we = ~de_nbyte and mem_wdata = de_w_data; for a read, SHALL drive mem_we = 0.
REQ-021 MEM: SHALL deassert mem_en and mem_we and go to WAIT; WAIT SHALL last exactly WAIT_CYCLES cycles before going to ACK, and SHALL be skipped when WAIT_CYCLES = 0.
REQ-022 ACK: SHALL pulse de_ack = 1 for exactly one cycle and go to IDLE.
REQ-023 ACK on a read: SHALL capture mem_rdata into de_r_data, holding it until the next read ACK; a write SHALL leave de_r_data unchanged.
REQ-024 Latency from the edge sampling de_req to the edge raising de_ack SHALL be 2 + WAIT_CYCLES cycles.
REQ-025 The requester SHALL drop de_req or present the next request on the edge at which it samples de_ack; a request held high SHALL be served back-to-back with no idle cycle beyond IDLE.
REQ-026 A write with de_nbyte = 4'b1111 SHALL still complete the handshake, with mem_en = 1 and mem_we = 0.
REQ-027 de_req dropping before de_ack is a protocol violation; the access SHALL still complete and de_ack SHALL still pulse.

Reset
REQ-028 Asserting rst_n = 0 SHALL asynchronously force IDLE, de_ack = 0, de_r_data = 0, mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0 and err = 0.
REQ-029 Reset mid-operation SHALL abort the access without any de_ack, and a memory write already strobed SHALL be allowed to land.

Configuration
REQ-030 With FS_BOUNDS_CHECK_EN defined: a word address >= FRAME_WORDS SHALL not assert mem_en, SHALL still complete the handshake with identical latency, SHALL return 0 on reads, and SHALL set err until reset.
REQ-031 Without FS_BOUNDS_CHECK_EN: every address SHALL be passed to memory, and err SHALL be tied to 0.

Structure
REQ-032 The state encoding, the DE_ADDR_W = 18 and MEM_ADDR_W = 16 constants, and the read/write encoding SHALL live in the shared framestore package used by the edge-detector and display blocks.
REQ-033 The wait-state counter SHALL be a sub-module named fs_wait_counter, with load, tick and done signals.

Verification
REQ-034 Write 0xDEADBEEF to addr 0x00010 with nbyte = 0000, WAIT_CYCLES = 0 -> mem_we = 1111 and mem_addr = 0x0004 one cycle after req is sampled; de_ack follows 2 cycles after req is sampled.
REQ-035 Read addr 0x00010 with memory model returning 0xDEADBEEF, WAIT_CYCLES = 3 -> de_ack 5 cycles after req is sampled with de_r_data = 0xDEADBEEF.
REQ-036 Write with nbyte = 1010 and data 0x11223344 -> mem_we = 0101, and only lanes 0 and 2 change in the model.
REQ-037 de_req held high for 4 reads -> exactly 4 de_ack pulses, each 3 cycles apart with WAIT_CYCLES = 0.
REQ-038 rst_n pulsed low during WAIT -> all outputs reach 0 immediately, no de_ack, and the next request is served normally.
REQ-039 FS_BOUNDS_CHECK_EN defined, FRAME_WORDS = 1024, read addr 0x01000 -> no mem_en, de_r_data = 0, err = 1 held until reset.
